// File: rtl/result_drain.sv
// result_drain: snapshots the N x N result matrix of the systolic array when
// `capture` pulses, then streams the elements out one per accepted beat over a
// valid/ready interface with out_idx / out_last sequencing.
// Optional macro RESULT_DRAIN_TRANSPOSE_EN switches the stream order from
// row-major to column-major (streams C^T); handshake and indices are unchanged.
module result_drain #(
   parameter int N  = 4,
   parameter int DW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic [N*N*DW-1:0] results_flat,
   output logic [DW-1:0]     out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_idx,
   output logic              out_last,
   output logic              busy,
   output logic              capture_drop
);

   localparam int NE = N * N;
   localparam int AW = (NE > 1) ? $clog2(NE) : 1;
   localparam logic [7:0] LAST_IDX = 8'(NE - 1);

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    idx_q, idx_d;
   logic          drop_q, drop_d;
   logic [DW-1:0] snap_q [NE];
   logic [DW-1:0] snap_d [NE];
   logic [AW-1:0] elem_sel;
   logic          transfer;

   assign out_valid    = (state_q == DRAIN);
   assign busy         = (state_q == DRAIN);
   assign out_idx      = idx_q;
   assign out_last     = out_valid && (idx_q == LAST_IDX);
   assign capture_drop = drop_q;
   assign transfer     = out_valid && out_ready;
   assign out_data     = snap_q[elem_sel];

`ifdef RESULT_DRAIN_TRANSPOSE_EN
   logic [7:0] trans_sel;

   // Column-major order: stream index idx maps to element (idx % N, idx / N).
   always_comb begin
      trans_sel = (idx_q % 8'(N)) * 8'(N) + idx_q / 8'(N);
      elem_sel  = trans_sel[AW-1:0];
   end
`else
   // Row-major order: the stream index is the flat element index.
   assign elem_sel = idx_q[AW-1:0];
`endif

   // Next-state logic: accept a capture in IDLE, advance on each transfer in DRAIN.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      drop_d  = 1'b0;
      snap_d  = snap_q;
      case (state_q)
         IDLE: begin
            if (capture) begin
               for (int i = 0; i < NE; i++) begin
                  snap_d[i] = results_flat[i*DW +: DW];
               end
               idx_d   = 8'd0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (capture) begin
               drop_d = 1'b1;
            end
            if (transfer) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = 8'd0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 8'd0;
         end
      endcase
   end

   // State, index, drop pulse and snapshot registers; reset wipes a drain in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 8'd0;
         drop_q  <= 1'b0;
         for (int i = 0; i < NE; i++) begin
            snap_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         drop_q  <= drop_d;
         snap_q  <= snap_d;
      end
   end

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: randomized self-checking bench for result_drain.
// The reference model is a queue of expected elements filled from the matrix
// at each accepted capture and popped on each handshake.
module tb_result_drain;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int NE = N * N;

   logic              clk;
   logic              rst;
   logic              capture;
   logic [N*N*DW-1:0] results_flat;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_idx;
   logic              out_last;
   logic              busy;
   logic              capture_drop;

   int num_vectors = 0;
   int num_errors  = 0;

   logic [DW-1:0] exp_q [$];
   int            exp_pos  = 0;
   bit            exp_drop = 0;
   int            dut_xfers = 0;

   result_drain #(.N(N), .DW(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .capture      (capture),
      .results_flat (results_flat),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_idx      (out_idx),
      .out_last     (out_last),
      .busy         (busy),
      .capture_drop (capture_drop)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_vectors++;
      if (observed !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Element (r,c) of the current input matrix, straight from the bus layout.
   function automatic logic [DW-1:0] matElem(input int r, input int c);
      return results_flat[(r*N + c)*DW +: DW];
   endfunction

   // Build the expected stream from the matrix in the configured order.
   task automatic loadModel();
      exp_q.delete();
      exp_pos = 0;
      for (int k = 0; k < NE; k++) begin
`ifdef RESULT_DRAIN_TRANSPOSE_EN
         exp_q.push_back(matElem(k % N, k / N));
`else
         exp_q.push_back(matElem(k / N, k % N));
`endif
      end
   endtask

   task automatic fillPattern(input int base);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            results_flat[(r*N + c)*DW +: DW] = DW'(base + 16*r + c);
   endtask

   task automatic fillRandom();
      for (int k = 0; k < NE; k++)
         results_flat[k*DW +: DW] = DW'($urandom);
   endtask

   // Compare every output against the model after a clock edge.
   task automatic checkAll();
      bit act = (exp_q.size() != 0);
      checkOutput("out_valid", 32'(out_valid), 32'(act));
      checkOutput("busy", 32'(busy), 32'(act));
      checkOutput("out_idx", 32'(out_idx), 32'(exp_pos));
      checkOutput("out_last", 32'(out_last), 32'(act && exp_pos == NE-1));
      checkOutput("capture_drop", 32'(capture_drop), 32'(exp_drop));
      if (act) checkOutput("out_data", 32'(out_data), 32'(exp_q[0]));
   endtask

   // One clock cycle: drive inputs, predict from the model, advance, check.
   task automatic applyStimulus(input logic cap, input logic rdy);
      bit xfer, accept, drop;
      capture   = cap;
      out_ready = rdy;
      xfer   = (exp_q.size() != 0) && rdy;
      accept = cap && (exp_q.size() == 0);
      drop   = cap && (exp_q.size() != 0);
      if (out_valid && rdy) dut_xfers++;
      @(posedge clk);
      #1;
      capture = 1'b0;
      if (xfer) begin
         void'(exp_q.pop_front());
         exp_pos++;
         if (exp_q.size() == 0) exp_pos = 0;
      end
      if (accept) loadModel();
      exp_drop = drop;
      checkAll();
   endtask

   // Synchronous reset for one cycle, then check the cleared outputs.
   task automatic doReset();
      rst = 1'b1;
      capture = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      exp_pos  = 0;
      exp_drop = 0;
      checkAll();
      checkOutput("reset_data", 32'(out_data), 32'd0);
      rst = 1'b0;
   endtask

   // Drain the current stream; mode 0 ready=1, 1 ready pattern 1,0,0, 2 random.
   task automatic drain(input int mode);
      int guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         case (mode)
            0: applyStimulus(1'b0, 1'b1);
            1: applyStimulus(1'b0, (guard % 3) == 0);
            default: applyStimulus(1'b0, 1'($urandom_range(0, 1)));
         endcase
         guard++;
      end
      if (guard >= 200) checkOutput("drain_timeout", 32'd1, 32'd0);
   endtask

   // Directed scenarios followed by a randomized soak.
   initial begin
      rst          = 1'b1;
      capture      = 1'b0;
      out_ready    = 1'b0;
      results_flat = '0;
      repeat (2) @(posedge clk);
      #1;
      doReset();

      // Basic drain with C(r,c) = 16r + c.
      fillPattern(0);
      applyStimulus(1'b1, 1'b1);
      drain(0);
      applyStimulus(1'b0, 1'b1);

      // Backpressure: every element delivered exactly once.
      fillRandom();
      applyStimulus(1'b1, 1'b1);
      dut_xfers = 0;
      drain(1);
      checkOutput("bp_transfers", 32'(dut_xfers), 32'(NE));
      applyStimulus(1'b0, 1'b0);

      // Capture at idx 5 with results changed to all ones is ignored.
      fillPattern(0);
      applyStimulus(1'b1, 1'b1);
      while (exp_pos < 5) applyStimulus(1'b0, 1'b1);
      results_flat = '1;
      applyStimulus(1'b1, 1'b1);
      drain(0);
      applyStimulus(1'b0, 1'b0);

      // Capture on the final transfer is also dropped.
      fillRandom();
      applyStimulus(1'b1, 1'b1);
      while (exp_q.size() > 1) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);

      // Reset at idx 7, then a clean restart.
      fillRandom();
      applyStimulus(1'b1, 1'b1);
      while (exp_pos < 7) applyStimulus(1'b0, 1'b1);
      out_ready = 1'b1;
      doReset();
      fillRandom();
      applyStimulus(1'b1, 1'b1);
      drain(2);

      // Back-to-back: second capture in the first IDLE cycle.
      fillPattern(0);
      applyStimulus(1'b1, 1'b1);
      drain(0);
      fillPattern(16'h100);
      applyStimulus(1'b1, 1'b1);
      drain(0);
      applyStimulus(1'b0, 1'b1);

      // Randomized soak.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) fillRandom();
         applyStimulus($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      end
      drain(0);
      applyStimulus(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_errors);
      $finish;
   end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Reader-side counterpart to the global load/control counter in the systolic matrix multiplier.
- When the array signals that a computation has finished, this block snapshots the N x N result matrix from the flattened PE accumulator bus.
- It then streams the elements out one per accepted beat over a valid/ready interface.
- An internal element counter sequences the drain and generates out_idx and out_last for the downstream consumer.

Parameters:
- N, 4, array dimension; the matrix holds N*N elements, N*N <= 256.
- DW, 16, width of one result element in bits.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- capture  input  1  one-cycle pulse: results_flat is valid and the drain should start.
- results_flat  input  N*N*DW  result matrix; element (r,c) is at bits [(r*N+c)*DW +: DW].
- out_data  output  DW  current element, driven from the snapshot.
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  downstream accepts the element this cycle.
- out_idx  output  8  stream index of the current element, 0..N*N-1.
- out_last  output  1  high with out_valid when out_idx == N*N-1.
- busy  output  1  high while in DRAIN.
- capture_drop  output  1  one-cycle pulse when a capture is ignored.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - out_valid=0, busy=0, out_idx=0, capture_drop=0.
  - All snapshot registers are cleared to 0, so out_data=0 and out_last=0.
  - Reset overrides everything else in the same cycle, including mid-drain; any remaining elements are discarded.
- FSM states: IDLE, DRAIN.
- IDLE:
  - out_valid=0, busy=0.
  - If capture=1: register all N*N elements into the snapshot, set idx=0, go to DRAIN.
  - out_valid rises on the next cycle, i.e. 1 cycle from capture to first valid.
- DRAIN:
  - out_valid=1, busy=1.
  - out_data = snapshot[element(idx)], out_idx = idx.
  - Transfer occurs on a cycle with out_valid && out_ready.
  - On a transfer with idx < N*N-1: idx increments by 1 the next cycle.
  - On a transfer with idx == N*N-1: go to IDLE, idx returns to 0, out_valid drops the next cycle.
  - With out_ready=0: out_data, out_idx and out_valid hold stable indefinitely (AXI-style: valid never drops without a transfer).
- Element ordering:
  - Default is row-major: element(idx) = (r = idx / N, c = idx % N).
  - idx is an 8-bit counter, so no wrap occurs when N*N <= 256.
- Capture during DRAIN, including the cycle of the final transfer:
  - The capture is ignored and the snapshot is not modified.
  - capture_drop pulses high for exactly 1 cycle.
  - The final transfer completes normally and the FSM returns to IDLE.
- Snapshot isolation: results_flat changes after capture have no effect on an in-progress drain.
- Throughput: with out_ready held at 1, N*N elements take N*N consecutive cycles; total is N*N+1 cycles from capture to the IDLE return.
- Back-to-back: a capture in the first IDLE cycle after a drain is accepted.

Optional Feature:
- Macro: RESULT_DRAIN_TRANSPOSE_EN.
- When defined:
  - Ordering is column-major: element(idx) = (r = idx % N, c = idx / N). This streams C^T, for consumers that need columns.
  - out_idx, out_last and the handshake are unchanged.
- When undefined: row-major ordering as above, with no transpose logic synthesized.

Test Plan:
- Basic drain:
  - Setup: N=4, DW=16, C(r,c)=16*r+c, out_ready=1, capture pulse at cycle t.
  - Expected: out_valid is high during cycles t+1..t+16. out_data is 0x00,0x01,0x02,0x03,0x10,...,0x33 and out_idx runs 0..15.
  - Expected: out_last is high only at idx 15; busy=0 at t+17.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,... while draining.
  - Expected: data/idx hold while ready=0. Every element is delivered exactly once, in order, with no duplicates; 16 transfers total.
- Ignored capture:
  - Stimulus: assert capture at idx 5 and change results_flat to all 0xFFFF.
  - Expected: capture_drop pulses for 1 cycle. The remaining elements keep the original values 0x11..0x33.
  - Stimulus: capture on the cycle of the final transfer.
  - Expected: also dropped; the FSM returns to IDLE.
- Reset mid-drain:
  - Stimulus: rst=1 at idx 7 with out_ready=1.
  - Expected: next cycle out_valid=0, busy=0, out_idx=0, out_data=0.
  - Expected: a later capture restarts cleanly from idx 0.
- Back-to-back:
  - Stimulus: a second capture with C'(r,c)=0x100+r*16+c in the first IDLE cycle after drain 1.
  - Expected: accepted with no capture_drop; 16 new elements follow.
- Transpose (RESULT_DRAIN_TRANSPOSE_EN defined):
  - Stimulus: same C as the basic drain.
  - Expected: out_data sequence is 0x00,0x10,0x20,0x30,0x01,...,0x33; out_last is high at idx 15.
